// File: rtl/prog_instr_mem.sv
// Program instruction memory: byte-serial loader plus
// single-cycle-latency word fetch port.
module prog_instr_mem #(
    parameter int          AddressWidth = 10,
    parameter logic [31:0] NopWord      = 32'h00000013
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    f_req_i,
    input  logic [AddressWidth-1:0] f_addr_i,
    output logic                    f_ready_o,
    output logic                    f_valid_o,
    output logic [31:0]             f_data_o,
    output logic                    f_err_o,
    input  logic                    ld_start_i,
    input  logic [AddressWidth-2:0] ld_len_i,
    input  logic                    ld_valid_i,
    input  logic [7:0]              ld_data_i,
    output logic                    ld_ready_o,
    output logic                    ld_done_o,
    output logic                    busy_o
);

    localparam int WordAw = AddressWidth - 2;
    localparam int Depth  = 2 ** WordAw;
    localparam logic [AddressWidth-2:0] DepthLen =
        (AddressWidth-1)'(Depth);

    typedef enum logic {
        IDLE,
        LOAD
    } state_t;

    state_t                  state_q;
    logic [31:0]             mem [Depth];
    logic [WordAw-1:0]       word_ptr_q;
    logic [1:0]              byte_cnt_q;
    logic [23:0]             asm_q;
    logic [AddressWidth-2:0] len_q;

    logic                    fetch_acc;
    logic                    byte_acc;
    logic                    last_byte;
    logic                    last_word;
    logic                    misaligned;
    logic [AddressWidth-2:0] len_clamped;

    assign f_ready_o  = (state_q == IDLE);
    assign ld_ready_o = (state_q == LOAD);
    assign busy_o     = (state_q == LOAD);

    assign fetch_acc  = f_req_i && f_ready_o;
    assign byte_acc   = ld_valid_i && ld_ready_o;
    assign last_byte  = byte_acc && (byte_cnt_q == 2'd3);
    assign last_word  = ({1'b0, word_ptr_q} == (len_q - 1'b1));
    assign misaligned = |f_addr_i[1:0];

    // Requests longer than the array are cut to the array depth.
    assign len_clamped = (ld_len_i > DepthLen) ? DepthLen : ld_len_i;

    // Control FSM, fetch response and byte assembly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            f_valid_o  <= 1'b0;
            f_err_o    <= 1'b0;
            f_data_o   <= '0;
            ld_done_o  <= 1'b0;
            word_ptr_q <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            len_q      <= '0;
        end else begin
            f_valid_o <= fetch_acc;
            ld_done_o <= 1'b0;
            if (fetch_acc) begin
                f_err_o  <= misaligned;
                f_data_o <= misaligned ? NopWord
                          : mem[f_addr_i[AddressWidth-1:2]];
            end
            unique case (state_q)
                IDLE: begin
                    if (ld_start_i && (|ld_len_i)) begin
                        state_q    <= LOAD;
                        word_ptr_q <= '0;
                        byte_cnt_q <= '0;
                        len_q      <= len_clamped;
                    end
                end
                LOAD: begin
                    if (byte_acc) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        unique case (byte_cnt_q)
                            2'd0: asm_q[7:0]   <= ld_data_i;
                            2'd1: asm_q[15:8]  <= ld_data_i;
                            2'd2: asm_q[23:16] <= ld_data_i;
                            2'd3: asm_q        <= asm_q;
                        endcase
                    end
                    if (last_byte) begin
                        // The pointer parks on the final word.
                        if (last_word) begin
                            state_q   <= IDLE;
                            ld_done_o <= 1'b1;
                        end else begin
                            word_ptr_q <= word_ptr_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory array write; contents are never reset.
    always_ff @(posedge clk_i) begin
        if ((state_q == LOAD) && last_byte) begin
            mem[word_ptr_q] <= {ld_data_i, asm_q};
        end
    end

endmodule
